spaceship2_sprite_fetch: RTL
============================

Name: spaceship2_sprite_fetch

Overview:
Upstream feeder of the spaceship-2 palette lookup. From the VGA scan position it decides whether the pixel lies inside the ship sprite and addresses the synchronous sprite ROM. It then delivers the 4-bit palette index and a sprite_on qualifier to the palette and colour mapper. It also owns the per-frame position latch and the damage-flash blink state machine.

Parameters:
SPR_W, 32, sprite width in pixels (power of two)
SPR_H, 32, sprite height in pixels (power of two)
ADDR_W, 10, ROM address width = log2(SPR_W*SPR_H)
TRANSPARENT_IDX, 0, palette index treated as transparent (chroma green)
FLASH_FRAMES, 30, frames the blink lasts after a hit
FLASH_PERIOD, 4, frames per blink half-period (power of two)

Ports:
Clk  in  1  pixel-domain clock
Reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse at start of vertical blank
ShipX  in  10  ship top-left X from game logic
ShipY  in  10  ship top-left Y from game logic
DrawX  in  10  current scan X
DrawY  in  10  current scan Y
hit  in  1  one-cycle pulse: ship took damage
rom_addr  out  ADDR_W  registered address to sprite ROM (1-cycle read latency)
rom_q  in  4  ROM data, valid one cycle after rom_addr
palette_index  out  4  index to spaceship2 palette
sprite_on  out  1  pixel is opaque ship pixel
flashing  out  1  blink state active

Behaviour:
- Reset values: rom_addr=0, palette_index=TRANSPARENT_IDX, sprite_on=0, flashing=0, latched PosX/PosY=0, flash counter=0, state IDLE.
- Position latch: on frame_start, PosX<=ShipX and PosY<=ShipY. Otherwise hold. Mid-frame ShipX/ShipY changes must not tear the sprite.
- Box test, stage 1: in_box = DrawX>=PosX && DrawX<PosX+SPR_W && DrawY>=PosY && DrawY<PosY+SPR_H.
  - Sums are computed at 11 bits; no wrap at 1023.
  - Sprite extending past screen edges is clipped naturally.
- Address, stage 1: rom_addr <= {DrawY-PosY, DrawX-PosX} truncated to log2(SPR_H) and log2(SPR_W) bits, row-major. When not in_box, rom_addr holds the computed (don't-care) value.
- Pipeline: stage1 registers rom_addr and in_box_d1. The ROM returns rom_q in the next cycle. Stage 2 registers the outputs and carries in_box_d2 alongside.
- Latency is exactly 2 Clk edges from DrawX/DrawY to palette_index/sprite_on. The downstream stage delays DrawX/DrawY to match.
- Output, stage 2:
  - palette_index <= in_box_d1 ? rom_q : TRANSPARENT_IDX.
  - sprite_on <= in_box_d1 && rom_q!=TRANSPARENT_IDX && !blank_now.
- Flash FSM, states IDLE and FLASH:
  - IDLE --hit--> FLASH; load cnt=FLASH_FRAMES.
  - FLASH: cnt decrements by 1 on each frame_start. When frame_start arrives with cnt==1: cnt<=0, go to IDLE.
  - hit in FLASH reloads cnt=FLASH_FRAMES (retrigger).
  - hit and frame_start in the same cycle: the load wins; no decrement.
  - flashing = (state==FLASH), registered.
  - blank_now = FLASH && cnt[log2(FLASH_PERIOD)] == 1, so the sprite is hidden on alternating FLASH_PERIOD-frame windows.
  - blank_now only masks sprite_on; palette_index is unaffected.
- Reset mid-operation: all pipeline and FSM state return to reset values on the next edge. Outputs are valid 2 cycles after Reset deasserts.

Decomposition:
- Shared package sprite_pkg: pixel coordinate typedef (10-bit), palette index typedef (4-bit), TRANSPARENT_IDX constant, flash FSM state enum.
- Sub-module flash_ctrl: the FSM plus counter, producing flashing and blank_now.
- Box/address logic and the pipeline stay in the top module.

Test Plan:
1. Reset held for 3 cycles -> palette_index=0, sprite_on=0, flashing=0, rom_addr=0.
2. Latch ship at (100,200) via frame_start; drive DrawX=105, DrawY=203 -> rom_addr=101 one edge later. Return rom_q=4'h5 -> palette_index=5, sprite_on=1 two edges after the pixel.
3. Same position; DrawX=132 and DrawX=99 (row 203) -> sprite_on=0, palette_index=0. DrawX=131 -> in box, rom_addr = 3*32+31 = 127.
4. In-box pixel with rom_q=0 -> palette_index=0, sprite_on=0 (transparent). Change ShipX to 300 mid-frame without frame_start -> addresses still computed from PosX=100.
5. hit pulse, then 30 frame_start pulses -> flashing=1 for exactly 30 frames, then 0. During FLASH, an in-box opaque pixel shows sprite_on=0 when cnt bit2=1 and sprite_on=1 otherwise.
6. hit coincident with frame_start while cnt=7 -> cnt reloads to 30, not 29. Reset asserted in FLASH -> flashing=0 on the next edge.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the spaceship-2 sprite path.
package sprite_pkg;

  // Screen coordinates and scan positions.
  typedef logic [9:0] coord_t;

  // Palette index delivered to the spaceship-2 palette.
  typedef logic [3:0] pidx_t;

  // Chroma-green entry of the palette; never drawn.
  localparam pidx_t TRANSPARENT_IDX = 4'd0;

  // Damage-flash blink state.
  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } flash_state_t;

endpackage

// File: rtl/flash_ctrl.sv
// Damage-flash blink controller: counts frames after a hit and produces
// the blink mask that hides the ship on alternating windows.
module flash_ctrl #(
  parameter int FLASH_FRAMES = 30,
  parameter int FLASH_PERIOD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_start,
  input  logic hit,
  output logic flashing,
  output logic blank_now
);
  import sprite_pkg::*;

  localparam int CW = $clog2(FLASH_FRAMES + 1);
  localparam int PB = $clog2(FLASH_PERIOD);
  localparam logic [CW-1:0] LOAD = CW'(FLASH_FRAMES);

  flash_state_t state;
  logic [CW-1:0] cnt;

  // Hit (re)loads the frame count and wins over a same-cycle frame_start; the last frame returns to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      flashing <= 1'b0;
    end else if (hit) begin
      state    <= FLASH;
      cnt      <= LOAD;
      flashing <= 1'b1;
    end else if (state == FLASH && frame_start) begin
      if (cnt == CW'(1)) begin
        state    <= IDLE;
        cnt      <= '0;
        flashing <= 1'b0;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign blank_now = (state == FLASH) && cnt[PB];

endmodule

// File: rtl/spaceship2_sprite_fetch.sv
// Spaceship-2 sprite fetch: box test and ROM addressing from the scan
// position, a two-edge pipeline to the palette, the per-frame position
// latch and the damage-flash blink.
module spaceship2_sprite_fetch #(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  parameter int ADDR_W = 10,
  parameter logic [3:0] TRANSPARENT_IDX = sprite_pkg::TRANSPARENT_IDX,
  parameter int FLASH_FRAMES = 30,
  parameter int FLASH_PERIOD = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic [9:0]        ShipX,
  input  logic [9:0]        ShipY,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              hit,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        palette_index,
  output logic              sprite_on,
  output logic              flashing
);
  import sprite_pkg::*;

  localparam int XB = $clog2(SPR_W);
  localparam int YB = $clog2(SPR_H);

  coord_t pos_x;
  coord_t pos_y;
  logic in_box;
  logic in_box_d1;
  logic blank_now;
  logic [XB-1:0] col;
  logic [YB-1:0] row;

  // Ship position is sampled once per frame so mid-frame moves cannot tear the sprite.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (frame_start) begin
      pos_x <= ShipX;
      pos_y <= ShipY;
    end
  end

  // Bounds are compared at 11 bits so a sprite near the right/bottom edge does not wrap.
  assign in_box = ({1'b0, DrawX} >= {1'b0, pos_x}) &&
                  ({1'b0, DrawX} <  ({1'b0, pos_x} + 11'(SPR_W))) &&
                  ({1'b0, DrawY} >= {1'b0, pos_y}) &&
                  ({1'b0, DrawY} <  ({1'b0, pos_y} + 11'(SPR_H)));

  assign col = XB'(DrawX - pos_x);
  assign row = YB'(DrawY - pos_y);

  // Stage 1: row-major ROM address and the box flag travelling with it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr  <= '0;
      in_box_d1 <= 1'b0;
    end else begin
      rom_addr  <= ADDR_W'({row, col});
      in_box_d1 <= in_box;
    end
  end

  // Stage 2: pixel colour from the ROM; blink only hides the pixel, the index is untouched.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      palette_index <= TRANSPARENT_IDX;
      sprite_on     <= 1'b0;
    end else begin
      palette_index <= in_box_d1 ? rom_q : TRANSPARENT_IDX;
      sprite_on     <= in_box_d1 && (rom_q != TRANSPARENT_IDX) && !blank_now;
    end
  end

  flash_ctrl #(
    .FLASH_FRAMES(FLASH_FRAMES),
    .FLASH_PERIOD(FLASH_PERIOD)
  ) u_flash (
    .clk        (Clk),
    .reset      (Reset),
    .frame_start(frame_start),
    .hit        (hit),
    .flashing   (flashing),
    .blank_now  (blank_now)
  );

endmodule
